hazard_track_unit: RTL

Producer side of the operand-forwarding path. It tracks destination registers of in-flight instructions through shadow ID/EX, EX/MEM and MEM/WB slots, and drives the EX/MEM and MEM/WB destination and reg-write fields that the forwarding unit consumes. It also detects the hazards forwarding cannot resolve (load-use, and HI/LO access during a multi-cycle mult/div) and issues stall, bubble and flush controls to the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_track_unit_md_busy_counter.sv | 48 ++++
 rtl/hazard_track_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard tracker: the shadow pipeline slot record and its idle value.
package hazard_pkg;

  localparam logic [31:0] REG_ZERO = '0;

  // rd is held zero-extended so the slot can drive the 32-bit forwarding fields directly.
  typedef struct packed {
    logic        valid;
    logic [31:0] rd;
    logic        reg_write;
    logic        mem_read;
  } pipe_slot_t;

  localparam pipe_slot_t SLOT_EMPTY = '{valid: 1'b0, rd: REG_ZERO, reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/hazard_track_unit_md_busy_counter.sv
// Mult/div occupancy counter: loads the operation latency on start, counts down,
// and pulses md_done on the cycle after the last busy cycle.
module md_busy_counter #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (start) begin
      count_d = is_div ? DIV_LD : MULT_LD;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
      done_d  = (count_q == ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign md_busy = (count_q != '0);
  assign md_done = done_q;

endmodule

// File: rtl/hazard_track_unit.sv
// Producer side of operand forwarding: shadow ID/EX, EX/MEM, MEM/WB destination slots,
// plus load-use and mult/div HI/LO hazard detection driving stall/bubble/flush.
module hazard_track_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_md_start,
  input  logic                  id_md_is_div,
  input  logic                  id_reads_hilo,
  input  logic                  ex_branch_taken,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic [31:0]           ex_mem_rd,
  output logic [31:0]           mem_wb_rd,
  output logic                  reg_write_ex_mem,
  output logic                  reg_write_mem_wb,
  output logic                  md_busy,
  output logic                  md_done
);

  pipe_slot_t idex_q, idex_d;
  pipe_slot_t exmem_q;
  pipe_slot_t memwb_q;

  logic [31:0] id_rs_x, id_rt_x, id_rd_x;
  logic        load_use, md_hazard, md_start;
  logic        unused_slot_bits;

  assign id_rs_x = {{(32-REG_ADDR_W){1'b0}}, id_rs};
  assign id_rt_x = {{(32-REG_ADDR_W){1'b0}}, id_rt};
  assign id_rd_x = {{(32-REG_ADDR_W){1'b0}}, id_rd};

  always_comb begin
    load_use = id_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != REG_ZERO) &
               ((id_uses_rs & (id_rs_x == idex_q.rd)) | (id_uses_rt & (id_rt_x == idex_q.rd)));
    md_hazard = id_valid & md_busy & (id_reads_hilo | id_md_start);
    // Controls are forced low during reset so every output reads 0 while rst is held.
    flush_if_id  = ~rst & ex_branch_taken;
    stall_if_id  = ~rst & ~ex_branch_taken & (load_use | md_hazard);
    bubble_id_ex = ~rst & (ex_branch_taken | stall_if_id);
    md_start     = id_valid & id_md_start & ~md_busy & ~ex_branch_taken;
  end

  always_comb begin
    idex_d = SLOT_EMPTY;
    if (!bubble_id_ex) begin
      idex_d.valid     = id_valid;
      idex_d.rd        = id_rd_x;
      idex_d.reg_write = id_reg_write;
      idex_d.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= SLOT_EMPTY;
      exmem_q <= SLOT_EMPTY;
      memwb_q <= SLOT_EMPTY;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= idex_q;
      memwb_q <= exmem_q;
    end
  end

  assign ex_mem_rd        = exmem_q.rd;
  assign mem_wb_rd        = memwb_q.rd;
  assign reg_write_ex_mem = exmem_q.valid & exmem_q.reg_write;
  assign reg_write_mem_wb = memwb_q.valid & memwb_q.reg_write;
  assign unused_slot_bits = exmem_q.mem_read ^ memwb_q.mem_read;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (id_md_is_div),
    .md_busy(md_busy),
    .md_done(md_done)
  );

endmodule
